// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: ALU opcodes, machine word, and multiply sequencer state.
`default_nettype none

package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } aluop_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_CALC = 2'd1,
    MS_DONE = 2'd2
  } mulstate_t;

  localparam int MUL_ITER = 32;

  // The shared ALU has no carry-out flag, so bit WIDTH of the sum is rebuilt
  // from the operand MSBs and the MSB of the truncated sum.
  function automatic logic add_carry(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 32x32->64 unsigned shift-and-add multiplier that borrows the shared ALU.
`default_nettype none

module alu_mul_seq
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo,
  output logic             alu_own,
  output aluop_t           alu_aluop,
  output logic [WIDTH-1:0] alu_porta,
  output logic [WIDTH-1:0] alu_portb,
  input  logic [WIDTH-1:0] alu_porto
);

  mulstate_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_mcand;
  logic             w_carry;
  logic             w_last;

  assign alu_aluop = ALU_ADD;
  assign alu_porta = r_acc_hi;
  assign alu_portb = r_mplier[0] ? r_mcand : '0;
  assign w_carry   = add_carry(alu_porta[WIDTH-1], alu_portb[WIDTH-1], alu_porto[WIDTH-1]);
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  assign busy       = (r_state == MS_CALC);
  assign alu_own    = (r_state == MS_CALC);
  assign done       = (r_state == MS_DONE);
  assign product_hi = r_acc_hi;
  assign product_lo = r_mplier;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= MS_IDLE;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
    end else begin
      case (r_state)
        MS_IDLE, MS_DONE: begin
          if (start) begin
            r_mcand  <= multiplicand;
            r_mplier <= multiplier;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_state  <= MS_CALC;
          end else begin
            r_state  <= MS_IDLE;
          end
        end
        MS_CALC: begin
          // Shift the 33-bit sum right one place; its LSB becomes a product bit.
          r_acc_hi <= {w_carry, alu_porto[WIDTH-1:1]};
          r_mplier <= {alu_porto[0], r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= MS_DONE;
          end
        end
        default: begin
          r_state <= MS_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: abstract timing/product model plus directed vectors.
`default_nettype none

module tb_alu_mul_seq;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic        alu_own;
  aluop_t      alu_aluop;
  logic [31:0] alu_porta;
  logic [31:0] alu_portb;
  logic [31:0] alu_porto;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Behavioural model state
  int          m_left = 0;
  bit          m_done = 0;
  logic [63:0] m_a    = '0;
  logic [63:0] m_b    = '0;
  logic [63:0] m_prod = '0;

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .busy        (busy),
    .done        (done),
    .product_hi  (product_hi),
    .product_lo  (product_lo),
    .alu_own     (alu_own),
    .alu_aluop   (alu_aluop),
    .alu_porta   (alu_porta),
    .alu_portb   (alu_portb),
    .alu_porto   (alu_porto)
  );

  // Shared ALU: only the add path matters here.
  assign alu_porto = (alu_aluop == ALU_ADD) ? (alu_porta + alu_portb) : 32'hDEADBEEF;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a request is taken whenever the unit is not computing; the result
  // appears 32 cycles later for exactly one cycle and is held afterwards.
  always @(posedge CLK) begin
    if (RST) begin
      m_left <= 0;
      m_done <= 0;
      m_prod <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1;
        m_prod <= m_a * m_b;
      end
    end else begin
      m_done <= 0;
      if (start) begin
        m_a    <= {32'd0, multiplicand};
        m_b    <= {32'd0, multiplier};
        m_left <= MUL_ITER;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", busy, m_left > 0);
      chk("alu_own", alu_own, m_left > 0);
      chk("done", done, m_done);
      chk("aluop", alu_aluop, ALU_ADD);
      chk("ports_known", $isunknown({alu_porta, alu_portb}), 0);
      if (m_left == 0) chk("product_model", {product_hi, product_lo}, m_prod);
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(posedge CLK); #1;
    start = 1; multiplicand = a; multiplier = b;
    @(posedge CLK); #1;
    start = 0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_done(input logic [63:0] exp, input int exp_lat, input string nm);
    int cyc = 0;
    bit seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (done === 1'b1) seen = 1;
    end
    chk({nm, "_done_seen"}, seen, 1);
    if (seen) begin
      chk({nm, "_product"}, {product_hi, product_lo}, exp);
      if (exp_lat > 0) chk({nm, "_latency"}, cyc, exp_lat);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int cyc;
    bit seen;
    RST = 1; start = 0; multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_own", alu_own, 0);
    chk("reset_product", {product_hi, product_lo}, 64'h0);
    RST = 0;
    chk_en = 1;

    issue(32'd3, 32'd5);
    wait_done(64'h0000_0000_0000_000F, 33, "basic");

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(64'hFFFF_FFFE_0000_0001, 33, "max");

    issue(32'h0000_0000, 32'h1234_5678);
    wait_done(64'h0, 33, "zero");

    issue(32'h8000_0000, 32'h0000_0002);
    wait_done(64'h0000_0001_0000_0000, 33, "msb");

    // A start raised mid-computation must not disturb the running operation.
    issue(32'd3, 32'd5);
    repeat (9) @(posedge CLK);
    #1; start = 1; multiplicand = 32'd7; multiplier = 32'd7;
    @(posedge CLK); #1; start = 0;
    wait_done(64'd15, -1, "ignored_start");
    repeat (40) @(posedge CLK);
    #1;
    chk("ignored_no_extra_op", {product_hi, product_lo}, 64'd15);

    // Reset part-way through an operation discards it.
    issue(32'hABCD_1234, 32'h5555_AAAA);
    repeat (15) @(posedge CLK);
    #1; RST = 1;
    @(posedge CLK); #1; RST = 0;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_product", {product_hi, product_lo}, 64'h0);
    repeat (20) @(posedge CLK);
    issue(32'd6, 32'd7);
    wait_done(64'h2A, 33, "after_reset");

    // Back-to-back: start held through DONE re-launches at the DONE edge.
    @(posedge CLK); #1;
    start = 1; multiplicand = 32'd11; multiplier = 32'd13;
    @(posedge CLK); #1;
    multiplicand = 32'd100; multiplier = 32'd200;
    wait_done(64'd143, 33, "b2b_first");
    @(posedge CLK); #1;
    start = 0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (done === 1'b1) seen = 1;
    end
    chk("b2b_second_seen", seen, 1);
    chk("b2b_second_gap", cyc, 33);
    chk("b2b_second_product", {product_hi, product_lo}, 64'h4E20);

    for (int i = 0; i < 1000; i++) begin
      ra = (i % 16 == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      rb = (i % 16 == 8) ? 32'hFFFF_FFFF : 32'($urandom);
      issue(ra, rb);
      wait_done({32'd0, ra} * {32'd0, rb}, 33, "rand");
    end

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned multiply sequencer that borrows the shared ALU to implement 32x32->64 shift-and-add multiplication.
- Sits beside the execute stage. While computing, it owns the ALU operand/opcode lines: it raises alu_own and the datapath mux selects its drives.
- Exposes a start/busy/done handshake to the controller and returns a registered 64-bit product.

Parameters:
- WIDTH, 32, operand width; must equal the word_t width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicand  input  WIDTH  operand A; captured when start is accepted.
- multiplier  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high in CALC.
- done  output  1  high for exactly one cycle (DONE state).
- product_hi  output  WIDTH  upper half of the result.
- product_lo  output  WIDTH  lower half of the result.
- alu_own  output  1  high in CALC; the datapath routes the sequencer's ALU drives.
- alu_aluop  output  aluop_t  always ALU_ADD.
- alu_porta  output  WIDTH  accumulator high word (acc_hi).
- alu_portb  output  WIDTH  mcand_r when lsb of mplier_r is 1, else 0.
- alu_porto  input  WIDTH  ALU sum.

Behaviour:
- Reset: state=IDLE, cnt=0, acc_hi=0, mplier_r=0, mcand_r=0. Outputs busy=0, done=0, alu_own=0, product_hi=0, product_lo=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: start=1 -> load mcand_r<=multiplicand, mplier_r<=multiplier, acc_hi<=0, cnt<=0; go to CALC.
  - CALC: one iteration per cycle.
    - carry = (a31&b31) | ((a31|b31) & ~porto31), where a=alu_porta and b=alu_portb.
    - acc_hi <= {carry, porto[WIDTH-1:1]}.
    - mplier_r <= {porto[0], mplier_r[WIDTH-1:1]}.
    - cnt <= cnt+1.
    - When cnt==WIDTH-1: go to DONE.
  - DONE: product_hi=acc_hi and product_lo=mplier_r (combinational from registers), done=1.
    - start=1 -> accepted exactly as in IDLE; go to CALC.
    - Else go to IDLE.
- Latency: start sampled at edge E0. Iterations at E1..E32. done high between E32 and E33. Back-to-back throughput is 33 cycles per multiply.
- Product hold: product_hi/lo keep their last value in IDLE and until the next accepted start. During CALC they show the working registers and are not valid.
- start during CALC: ignored. Operands are not re-captured and no error is signalled.
- Operand stability: multiplicand/multiplier may change after acceptance without effect.
- ALU ownership: alu_own=0 in IDLE and DONE. Port drives are don't-care when alu_own=0, but the block still holds them stable (no X).
- Reset mid-operation: RST=1 in any state -> IDLE next edge with all reset values. The partial result is discarded and no done pulse occurs.
- Arithmetic: unsigned only. The carry is derived locally because the ALU flags provide no carry-out. The 64-bit result is exact and cannot overflow.
- Counter: cnt saturates by leaving CALC and never wraps within an operation.

Decomposition:
- cpu_types_pkg additions:
  - typedef enum logic [1:0] {MS_IDLE, MS_CALC, MS_DONE} mulstate_t.
  - constant MUL_ITER = 32.
- Reuse aluop_t and word_t from cpu_types_pkg; no new ALU opcodes.
- Single module, no sub-module. The carry equation may be a local function.
- An optional mul_if interface (modports ms / tb) mirrors the existing alu_if style for the handshake ports.

Test Plan:
- Basic timing: multiplicand=3, multiplier=5, start pulse at E0 -> busy high at E1..E32; done=1 exactly one cycle after E32; product_hi=0x00000000, product_lo=0x0000000F.
- Max operands: 0xFFFFFFFF * 0xFFFFFFFF -> product_hi=0xFFFFFFFE, product_lo=0x00000001. Checks that the carry path is exercised every cycle.
- Zero and mixed operands:
  - 0x00000000 * 0x12345678 -> 0 / 0.
  - 0x80000000 * 0x00000002 -> hi=0x00000001, lo=0x00000000.
- Ignored start: start re-asserted at E10 with new operands (7*7) -> result is still 15 from scenario 1; no extra done pulse.
- Reset mid-operation: RST asserted at E16 -> state IDLE, busy=0, done=0, products=0 at the next edge, with no done pulse. A fresh start of 6*7 then yields 0x2A.
- Back-to-back: start held high through DONE -> second operation accepted at the DONE edge; second done follows 33 cycles after the first. Random reference model compares 1000 random operand pairs.
